sub_serial_nbit: RTL and testbench

Bit-serial N-bit subtractor built around one full-adder slice. It accepts two WIDTH-bit operands with a start/done handshake and computes A − B LSB-first, one bit per clock. The B bit is inverted and the carry register is seeded with 1. It sits beside the combinational adder datapath as the area-minimal, multi-cycle arithmetic unit, and supplies difference, carry/borrow, overflow and zero flags.

---
 rtl/sub_serial_nbit.sv | 135 +++++++++++++
 tb/tb_sub_serial_nbit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial_nbit.sv
// sub_serial_nbit: bit-serial WIDTH-bit subtractor built from a single
// full-adder slice. Computes A - B LSB-first, one bit per clock, by inverting
// the B bit and seeding the carry with 1. Results and flags are registered
// and update together when the run completes.
//
// Optional feature macro: SUB_SERIAL_ADD_MODE_EN
//   When defined, an 'op' input exists (1 = add, 0 = subtract).
//   When undefined, the block is subtract-only.
module sub_serial_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUB_SERIAL_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             sub_r;

  logic             sub_in;
  logic             accept;
  logic             last_bit;
  logic             bb;
  logic             s;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;

`ifdef SUB_SERIAL_ADD_MODE_EN
  assign sub_in = ~op;
`else
  assign sub_in = 1'b1;
`endif

  // The full-adder slice operating on the current LSBs of the shift registers.
  // While in RUN, c is the carry into the bit position being processed, so on
  // the last bit it is exactly the carry into the MSB slice.
  assign bb       = b_sh[0] ^ sub_r;
  assign s        = a_sh[0] ^ bb ^ c;
  assign c_next   = (a_sh[0] & bb) | (c & (a_sh[0] ^ bb));
  assign sum_next = {s, sum_sh[WIDTH-1:1]};

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE waits for start, RUN lasts WIDTH cycles, DONE lasts one.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (cnt == LAST_BIT) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Serial datapath: load operands on accept, then process one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      sub_r  <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      cnt    <= '0;
      c      <= sub_in;
      sub_r  <= sub_in;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_next;
      cnt    <= cnt + CNT_W'(1);
      c      <= c_next;
    end
  end

  // Outputs update together only on the final bit and hold until the next completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (last_bit) begin
      result    <= sum_next;
      carry_out <= c_next;
      overflow  <= c ^ c_next;
      zero      <= (sum_next == '0);
    end
  end

endmodule

// File: tb/tb_sub_serial_nbit.sv
// Testbench for sub_serial_nbit (WIDTH=8): directed vector table, hand-written
// busy/reset/back-to-back sequences, and randomized operands checked against
// an arithmetic reference model.
module tb_sub_serial_nbit;

  localparam int W = 8;

`ifdef SUB_SERIAL_ADD_MODE_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_s;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int n_compared = 0;
  int n_failed   = 0;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_add;
    res_t         exp;
  } vec_t;

  sub_serial_nbit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SUB_SERIAL_ADD_MODE_EN
    .op        (op_s),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic is_add);
    res_t m;
    int ux, uy, sx, sy, full, sfull;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (is_add) begin
      full    = ux + uy;
      sfull   = sx + sy;
      m.carry = (full >= (1 << W));
    end else begin
      full    = ux - uy;
      sfull   = sx - sy;
      m.carry = (ux >= uy);
    end
    m.result = full[W-1:0];
    m.ovf    = (sfull > ((1 << (W - 1)) - 1)) || (sfull < -(1 << (W - 1)));
    m.zero   = (m.result == '0);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Issue one operation from idle and observe it until done has dropped.
  // poke_at > 0 pulses start during the run at that negedge index.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic top,
                               input int poke_at, output res_t got, output int busy_cycles,
                               output int done_at, output int done_width, output int run_changes,
                               output int overlap);
    res_t snap;
    @(negedge clk);
    a = ta; b = tbv; op_s = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op_s = 1'($urandom);
    snap = '{result, carry_out, overflow, zero};
    got = '0;
    busy_cycles = 0; done_at = 0; done_width = 0; run_changes = 0; overlap = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) begin
        busy_cycles++;
        if ({result, carry_out, overflow, zero} !== snap) run_changes++;
      end
      if (busy && done) overlap++;
      if (done) begin
        if (done_at == 0) begin
          done_at = k;
          got = '{result, carry_out, overflow, zero};
        end
        done_width++;
      end
      if (done_at != 0 && !done) break;
      start = (k == poke_at);
      if (k == poke_at) begin
        a = 8'h00; b = 8'h00;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                             input logic top, input res_t exp, input int poke_at);
    res_t got;
    int bc, da, dw, rc, ov;
    applyStimulus(ta, tbv, top, poke_at, got, bc, da, dw, rc, ov);
    checkOutput({tag, " busy_cycles"}, 32'(bc), 32'(W));
    checkOutput({tag, " done_latency"}, 32'(da), 32'(W + 1));
    checkOutput({tag, " done_width"}, 32'(dw), 32'd1);
    checkOutput({tag, " stable_during_run"}, 32'(rc), 32'd0);
    checkOutput({tag, " busy_done_overlap"}, 32'(ov), 32'd0);
    checkOutput({tag, " result"}, 32'(got.result), 32'(exp.result));
    checkOutput({tag, " carry_out"}, 32'(got.carry), 32'(exp.carry));
    checkOutput({tag, " overflow"}, 32'(got.ovf), 32'(exp.ovf));
    checkOutput({tag, " zero"}, 32'(got.zero), 32'(exp.zero));
  endtask

  initial begin
    vec_t vecs[$];
    res_t exp;
    int first_done, second_done, done_seen;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op_s = 1'b0;

    // Directed vectors: {a, b, is_add, {result, carry, overflow, zero}}.
    vecs.push_back('{8'h05, 8'h03, 1'b0, '{8'h02, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{8'h03, 8'h05, 1'b0, '{8'hFE, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{8'h80, 8'h01, 1'b0, '{8'h7F, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{8'h3C, 8'h3C, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}});
    vecs.push_back('{8'h00, 8'h01, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}});
    vecs.push_back('{8'h00, 8'h00, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}});
    if (ADD_EN) begin
      vecs.push_back('{8'h7F, 8'h01, 1'b1, '{8'h80, 1'b0, 1'b1, 1'b0}});
      vecs.push_back('{8'hFF, 8'h01, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1}});
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset flags", 32'({carry_out, overflow, zero}), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].is_add, vecs[i].exp, 0);
    end

    // Start pulsed mid-run is ignored and not queued.
    runAndCheck("ignored_start", 8'h05, 8'h03, 1'b0, '{8'h02, 1'b1, 1'b0, 1'b0}, 3);
    @(negedge clk);
    checkOutput("no_queued_start busy", 32'(busy), 32'd0);

    // Reset mid-run aborts and clears everything.
    @(negedge clk);
    a = 8'h80; b = 8'h01; op_s = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst result", 32'(result), 32'd0);
    checkOutput("midrst flags", 32'({carry_out, overflow, zero}), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    checkOutput("midrst no_activity", 32'(done_seen), 32'd0);
    runAndCheck("after_reset", 8'h05, 8'h03, 1'b0, '{8'h02, 1'b1, 1'b0, 1'b0}, 0);

    // Start held high: back-to-back runs at the minimum issue interval.
    @(negedge clk);
    a = 8'h80; b = 8'h01; op_s = 1'b0; start = 1'b1;
    first_done = 0; second_done = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done && first_done == 0) first_done = k;
      else if (done && second_done == 0) begin
        second_done = k;
        start = 1'b0;
        exp = model(8'h80, 8'h01, 1'b0);
        checkOutput("held_start result", 32'(result), 32'(exp.result));
        break;
      end
    end
    start = 1'b0;
    checkOutput("held_start interval", 32'(second_done - first_done), 32'(W + 2));
    @(negedge clk);
    @(negedge clk);
    checkOutput("held_start stops", 32'(busy), 32'd0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      logic rop;
      ra  = W'($urandom);
      rb  = W'($urandom_range(0, 3) == 0 ? int'(ra) : int'($urandom));
      rop = ADD_EN ? 1'($urandom) : 1'b0;
      runAndCheck($sformatf("rand%0d", i), ra, rb, rop, model(ra, rb, rop), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
